// File: rtl/vram_pkg.sv
// Shared VRAM definitions used by the screen-dump engine and the VRAM write controller.
package vram_pkg;

  localparam int unsigned VRAM_X_W    = 6;
  localparam int unsigned VRAM_Y_W    = 5;
  localparam int unsigned VRAM_ADDR_W = 11;

  localparam logic [7:0] CHAR_CR  = 8'h0D;
  localparam logic [7:0] CHAR_LF  = 8'h0A;
  localparam logic [7:0] CHAR_SUB = 8'h2E;

  // VRAM address is {y, x}
  typedef logic [VRAM_ADDR_W-1:0] vram_addr_t;

endpackage

// File: rtl/vram_dump.sv
// Screen-dump engine: reads every VRAM cell row-major and streams it to the UART TX byte
// stream, appending CR LF after each row.
// Build option: define VRAM_DUMP_SANITIZE_EN to replace non-printable captured bytes by '.'.
module vram_dump
  import vram_pkg::*;
#(
  parameter int unsigned COLS   = 64,
  parameter int unsigned ROWS   = 32,
  parameter int unsigned RD_LAT = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_vram_req,
  input  logic             i_vram_gnt,
  output vram_addr_t       o_vram_addr,
  output logic             o_vram_ce,
  output logic             o_vram_wre,
  output logic             o_vram_clk,
  input  logic [7:0]       i_vram_dout,
  output logic [7:0]       o_data,
  output logic             o_data_valid,
  input  logic             i_data_ready
);

  typedef enum logic [2:0] {
    StIdle, StReq, StRead, StWait, StSend, StCr, StLf, StDone
  } state_e;

  localparam logic [VRAM_X_W-1:0] X_LAST   = VRAM_X_W'(COLS - 1);
  localparam logic [VRAM_Y_W-1:0] Y_LAST   = VRAM_Y_W'(ROWS - 1);
  localparam logic [7:0]          LAT_LAST = 8'(RD_LAT - 1);

  state_e                r_state;
  state_e                w_state_d;
  logic [VRAM_X_W-1:0]   r_x;
  logic [VRAM_Y_W-1:0]   r_y;
  logic [7:0]            r_data;
  logic [7:0]            r_lat;
  logic                  w_xfer;
  logic                  w_x_last;
  logic                  w_y_last;
  logic                  w_lat_done;
  logic [7:0]            w_cap;

  assign w_xfer     = o_data_valid & i_data_ready;
  assign w_x_last   = (r_x == X_LAST);
  assign w_y_last   = (r_y == Y_LAST);
  assign w_lat_done = (r_lat == LAT_LAST);

`ifdef VRAM_DUMP_SANITIZE_EN
  assign w_cap = ((i_vram_dout < 8'h20) || (i_vram_dout >= 8'h7F)) ? CHAR_SUB : i_vram_dout;
`else
  assign w_cap = i_vram_dout;
`endif

  assign o_vram_addr = {r_y, r_x};
  assign o_vram_wre  = 1'b0;
  assign o_vram_clk  = i_clk;
  assign o_data      = r_data;

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Next-state logic; after a byte the next read goes straight to READ while granted
  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StIdle: if (i_start) w_state_d = StReq;
      StReq:  if (i_vram_gnt) w_state_d = StRead;
      StRead: w_state_d = i_vram_gnt ? StWait : StReq;
      StWait: if (w_lat_done) w_state_d = StSend;
      StSend: begin
        if (w_xfer) begin
          if (w_x_last)        w_state_d = StCr;
          else if (i_vram_gnt) w_state_d = StRead;
          else                 w_state_d = StReq;
        end
      end
      StCr:   if (w_xfer) w_state_d = StLf;
      StLf: begin
        if (w_xfer) begin
          if (w_y_last)        w_state_d = StDone;
          else if (i_vram_gnt) w_state_d = StRead;
          else                 w_state_d = StReq;
        end
      end
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  // Outputs decoded from state; ce is suppressed if the grant is gone in READ
  always_comb begin
    o_busy       = 1'b0;
    o_vram_req   = 1'b0;
    o_done       = 1'b0;
    o_vram_ce    = 1'b0;
    o_data_valid = 1'b0;
    case (r_state)
      StIdle: ;
      StDone: o_done = 1'b1;
      default: begin
        o_busy     = 1'b1;
        o_vram_req = 1'b1;
      end
    endcase
    if (r_state == StRead) o_vram_ce = i_vram_gnt;
    if ((r_state == StSend) || (r_state == StCr) || (r_state == StLf)) o_data_valid = 1'b1;
  end

  // Cell counters, latency counter and TX byte register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_x    <= '0;
      r_y    <= '0;
      r_data <= 8'h00;
      r_lat  <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (i_start) begin
            r_x <= '0;
            r_y <= '0;
          end
        end
        StRead: r_lat <= '0;
        StWait: begin
          if (w_lat_done) r_data <= w_cap;
          else            r_lat  <= r_lat + 8'd1;
        end
        StSend: begin
          if (w_xfer) begin
            if (w_x_last) begin
              r_x    <= '0;
              r_data <= CHAR_CR;
            end else begin
              r_x <= r_x + 1'b1;
            end
          end
        end
        StCr: if (w_xfer) r_data <= CHAR_LF;
        StLf: begin
          if (w_xfer && !w_y_last) begin
            r_y <= r_y + 1'b1;
            r_x <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vram_dump.sv
// Self-checking bench for vram_dump: VRAM model, randomized ready/grant, reference stream model.
module tb_vram_dump;

  localparam int unsigned COLS = 4;
  localparam int unsigned ROWS = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        busy, done, vram_req, vram_gnt, vram_ce, vram_wre, vram_clk;
  logic [10:0] vram_addr;
  logic [7:0]  vram_dout = 8'h00;
  logic [7:0]  data;
  logic        data_valid, data_ready;

  vram_dump #(.COLS(COLS), .ROWS(ROWS), .RD_LAT(1)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_start      (start),
    .o_busy       (busy),
    .o_done       (done),
    .o_vram_req   (vram_req),
    .i_vram_gnt   (vram_gnt),
    .o_vram_addr  (vram_addr),
    .o_vram_ce    (vram_ce),
    .o_vram_wre   (vram_wre),
    .o_vram_clk   (vram_clk),
    .i_vram_dout  (vram_dout),
    .o_data       (data),
    .o_data_valid (data_valid),
    .i_data_ready (data_ready)
  );

  initial forever #5 clk = ~clk;

  // VRAM model, one-cycle read latency
  logic [7:0] mem [0:2047];
  int n_reads = 0;
  always @(posedge clk) begin
    if (vram_ce) begin
      vram_dout <= mem[vram_addr];
      n_reads   <= n_reads + 1;
    end
  end

  // Stream monitor: logs transferred bytes and counts protocol events
  logic [7:0] log_q[$];
  int   done_total = 0, hold_bad = 0, ce_nognt = 0, c_hold = 0;
  logic prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall && (!data_valid || data != prev_data)) hold_bad <= hold_bad + 1;
      prev_stall <= data_valid && !data_ready;
      prev_data  <= data;
      if (data_valid && data_ready) log_q.push_back(data);
      if (done) done_total <= done_total + 1;
      if (!vram_gnt && vram_ce) ce_nognt <= ce_nognt + 1;
      if (data_valid && !data_ready && data == 8'h43) c_hold <= c_hold + 1;
    end
  end

  // Stimulus controls written only by the main process
  int start_req = 0;
  int inj_byte = -1, stall_byte = -1, stall_len = 0, gnt_after = 0, gnt_len = 0;
  bit rand_ready = 0, rand_gnt = 0;

  // Input driver: start pulses, ready stalls, grant drops
  int start_ack = 0, drv_base = 0, rd_base = 0, stall_cyc = 0, gnt_cyc = 0;
  initial begin
    int nb;
    start      = 1'b0;
    data_ready = 1'b1;
    vram_gnt   = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      start = 1'b0;
      if (start_req != start_ack) begin
        start     = 1'b1;
        start_ack = start_ack + 1;
        drv_base  = log_q.size();
        rd_base   = n_reads;
        stall_cyc = 0;
        gnt_cyc   = 0;
      end
      nb = log_q.size() - drv_base;
      if (inj_byte >= 0 && nb == inj_byte && busy) start = 1'b1;
      if (nb == stall_byte && data_valid && stall_cyc < stall_len) begin
        data_ready = 1'b0;
        stall_cyc  = stall_cyc + 1;
      end else begin
        data_ready = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
      end
      if (gnt_len > 0 && (n_reads - rd_base) >= gnt_after && gnt_cyc < gnt_len) begin
        vram_gnt = 1'b0;
        gnt_cyc  = gnt_cyc + 1;
      end else begin
        vram_gnt = rand_gnt ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
    end
  end

  int n_checks = 0, n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] model_char(input logic [7:0] c);
`ifdef VRAM_DUMP_SANITIZE_EN
    return ((c < 8'h20) || (c >= 8'h7F)) ? 8'h2E : c;
`else
    return c;
`endif
  endfunction

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_busy"},  busy,       0);
    check_eq({tag, "_done"},  done,       0);
    check_eq({tag, "_req"},   vram_req,   0);
    check_eq({tag, "_ce"},    vram_ce,    0);
    check_eq({tag, "_valid"}, data_valid, 0);
    check_eq({tag, "_data"},  data,       0);
    check_eq({tag, "_addr"},  vram_addr,  0);
    check_eq({tag, "_wre"},   vram_wre,   0);
  endtask

  // Runs one full dump and compares the stream against the row-major reference
  task automatic run_dump(input string tag, output int base);
    logic [7:0] exp_q[$];
    int dbase, hbase, cbase, n;
    for (int y = 0; y < ROWS; y++) begin
      for (int x = 0; x < COLS; x++) exp_q.push_back(model_char(mem[y * 64 + x]));
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
    end
    base  = log_q.size();
    dbase = done_total;
    hbase = hold_bad;
    cbase = ce_nognt;
    start_req = start_req + 1;
    repeat (3) @(negedge clk);
    #1;
    check_eq({tag, "_busy_hi"}, busy, 1);
    for (int i = 0; i < 5000 && done_total == dbase; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    #1;
    check_eq({tag, "_done_once"}, done_total - dbase, 1);
    check_eq({tag, "_busy_lo"}, busy, 0);
    check_eq({tag, "_len"}, log_q.size() - base, exp_q.size());
    n = log_q.size() - base;
    if (n > exp_q.size()) n = exp_q.size();
    for (int i = 0; i < n; i++) check_eq($sformatf("%s_b%0d", tag, i), log_q[base + i], exp_q[i]);
    check_eq({tag, "_hold"}, hold_bad - hbase, 0);
    check_eq({tag, "_ce_nognt"}, ce_nognt - cbase, 0);
  endtask

  initial begin
    int base, cb, nb;
    string s;
    rst_n = 1'b0;
    for (int i = 0; i < 2048; i++) mem[i] = 8'h2D;
    s = "ABCDEFGH";
    for (int i = 0; i < 8; i++) mem[(i / 4) * 64 + (i % 4)] = s[i];

    repeat (2) @(negedge clk);
    #1;
    check_reset_outputs("rst");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: basic stream "ABCD\r\nEFGH\r\n"
    run_dump("t1", base);

    // 2: ready low for 7 cycles on the 3rd byte
    cb = c_hold;
    stall_byte = 2;
    stall_len  = 7;
    run_dump("t2", base);
    check_eq("t2_c_held", c_hold - cb, 7);
    stall_byte = -1;
    stall_len  = 0;

    // 3: grant dropped for 20 cycles after the 2nd read
    gnt_after = 2;
    gnt_len   = 20;
    run_dump("t3", base);
    gnt_len = 0;

    // 4: start re-pulsed mid-dump
    inj_byte = 3;
    run_dump("t4", base);
    inj_byte = -1;

    // 5: reset after byte 5, then restart
    base = log_q.size();
    start_req = start_req + 1;
    nb = 0;
    for (int i = 0; i < 2000 && nb < 5; i++) begin
      @(negedge clk);
      #1;
      nb = log_q.size() - base;
    end
    check_eq("t5_reach5", nb, 5);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("t5");
    repeat (4) @(negedge clk);
    check_eq("t5_no_more", log_q.size() - base, 5);
    rst_n = 1'b1;
    @(negedge clk);
    run_dump("t5r", base);

    // 6: control byte and printable byte
    mem[0] = 8'h07;
    mem[1] = 8'h41;
    run_dump("t6", base);
`ifdef VRAM_DUMP_SANITIZE_EN
    check_eq("t6_ctl", log_q[base], 8'h2E);
`else
    check_eq("t6_ctl", log_q[base], 8'h07);
`endif
    check_eq("t6_ok", log_q[base + 1], 8'h41);

    // Randomized contents with random ready and grant
    rand_ready = 1;
    rand_gnt   = 1;
    for (int k = 0; k < 4; k++) begin
      for (int y = 0; y < ROWS; y++)
        for (int x = 0; x < COLS; x++) mem[y * 64 + x] = 8'($urandom_range(0, 255));
      run_dump($sformatf("rnd%0d", k), base);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
